// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: issues single-beat reads for the current PC, captures the
// returned word into the IF/ID register, honours decode stall and redirect flush, and
// reports misaligned-PC and fetch-timeout errors through a sticky error code.
module instr_fetch_stage #(
  parameter logic [31:0] NOP_WORD = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] pc_in,
  output logic        pc_write,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [1:0]  err_code
);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHold,
    StErr
  } state_e;

  localparam logic [1:0] ErrNone      = 2'b00;
  localparam logic [1:0] ErrMisalign  = 2'b01;
  localparam logic [1:0] ErrTimeout   = 2'b10;

  // Last count value before the un-acked request that trips the timeout.
  localparam logic [7:0] LastWaitCnt = 8'(TIMEOUT - 1);

  state_e      r_state;
  logic        r_if_valid;
  logic [31:0] r_if_instr;
  logic [31:0] r_if_pc;
  logic [1:0]  r_err_code;
  logic [7:0]  r_wait_cnt;

  logic w_in_fetch;
  logic w_misaligned;
  logic w_hold_req;
  logic w_req;
  logic w_capture;

  // Request only from FETCH, aligned PC, no redirect, and room in IF/ID.
  always_comb begin
    w_in_fetch   = (r_state == StFetch);
    w_misaligned = (pc_in[1:0] != 2'b00);
    w_hold_req   = r_if_valid & stall;
    w_req        = w_in_fetch & ~flush & ~w_hold_req & ~w_misaligned;
    w_capture    = w_req & imem_ack;
  end

  assign imem_req    = w_req;
  assign imem_addr   = pc_in;
  // Advancing the PC is tied to an accepted beat, so it can never fire without an ack.
  assign pc_write    = w_capture;
  assign if_valid    = r_if_valid;
  assign if_instr    = r_if_instr;
  assign if_pc       = r_if_pc;
  assign if_pc_plus4 = r_if_pc + 32'd4;
  assign err_code    = r_err_code;

  // FSM plus IF/ID register, error code and wait counter; flush overrides everything.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= StIdle;
      r_if_valid <= 1'b0;
      r_if_instr <= NOP_WORD;
      r_if_pc    <= 32'h0000_0000;
      r_err_code <= ErrNone;
      r_wait_cnt <= 8'd0;
    end else if (flush) begin
      r_state    <= StFetch;
      r_if_valid <= 1'b0;
      r_if_instr <= NOP_WORD;
      r_err_code <= ErrNone;
      r_wait_cnt <= 8'd0;
    end else begin
      case (r_state)
        StIdle: begin
          r_state    <= StFetch;
          r_wait_cnt <= 8'd0;
        end

        StFetch: begin
          if (w_hold_req) begin
            // Decode is blocked on a held word: park without requesting.
            r_state    <= StHold;
            r_wait_cnt <= 8'd0;
          end else if (w_misaligned) begin
            r_state    <= StErr;
            r_err_code <= ErrMisalign;
            r_if_valid <= 1'b0;
            r_wait_cnt <= 8'd0;
          end else if (imem_ack) begin
            r_if_valid <= 1'b1;
            r_if_instr <= imem_rdata;
            r_if_pc    <= pc_in;
            r_wait_cnt <= 8'd0;
            r_state    <= stall ? StHold : StFetch;
          end else begin
            // No new word this cycle; any held word was consumed by decode.
            r_if_valid <= 1'b0;
            if (r_wait_cnt == LastWaitCnt) begin
              r_state    <= StErr;
              r_err_code <= ErrTimeout;
              r_wait_cnt <= 8'd0;
            end else begin
              r_wait_cnt <= r_wait_cnt + 8'd1;
            end
          end
        end

        StHold: begin
          if (!stall) begin
            // Decode takes the held word at this edge.
            r_state    <= StFetch;
            r_if_valid <= 1'b0;
          end
        end

        StErr: begin
          r_if_valid <= 1'b0;
          r_wait_cnt <= 8'd0;
        end

        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage: models the upstream PC register and checks
// reset, streaming, stall/hold, flush, misalignment, timeout, wrap and async reset.
module tb_instr_fetch_stage;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] pc_in;
  logic        pc_write;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        flush;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [1:0]  err_code;

  int n_checks = 0;
  int n_errs   = 0;
  int n_pcw    = 0;

  localparam logic [31:0] P0 = 32'h0040_0004;

  instr_fetch_stage #(
    .NOP_WORD (32'h0000_0000),
    .TIMEOUT  (16)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .pc_in       (pc_in),
    .pc_write    (pc_write),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .flush       (flush),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_pc_plus4 (if_pc_plus4),
    .err_code    (err_code)
  );

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: sample pc_write before the edge, then advance the modelled PC register.
  task automatic step();
    logic pw;
    #1;
    pw = pc_write;
    if (pw) n_pcw++;
    @(posedge Clk);
    #1;
    if (pw) pc_in = pc_in + 32'd4;
  endtask

  initial begin
    Reset      = 1'b1;
    pc_in      = 32'h0040_0000;
    imem_ack   = 1'b1;
    imem_rdata = 32'h2008_0005;
    stall      = 1'b0;
    flush      = 1'b0;
    @(posedge Clk);
    @(posedge Clk);
    #1;

    // Reset values
    check_eq("rst_req",   32'(imem_req), 32'd0);
    check_eq("rst_pcw",   32'(pc_write), 32'd0);
    check_eq("rst_valid", 32'(if_valid), 32'd0);
    check_eq("rst_instr", if_instr, 32'h0000_0000);
    check_eq("rst_pc",    if_pc, 32'h0000_0000);
    check_eq("rst_err",   32'(err_code), 32'd0);

    // Release: one IDLE cycle, then fetch
    Reset = 1'b0;
    #1;
    check_eq("idle_req", 32'(imem_req), 32'd0);
    check_eq("idle_pcw", 32'(pc_write), 32'd0);
    step();
    check_eq("f1_req",  32'(imem_req), 32'd1);
    check_eq("f1_pcw",  32'(pc_write), 32'd1);
    check_eq("f1_addr", imem_addr, 32'h0040_0000);
    step();
    check_eq("f1_valid", 32'(if_valid), 32'd1);
    check_eq("f1_instr", if_instr, 32'h2008_0005);
    check_eq("f1_pc",    if_pc, 32'h0040_0000);
    check_eq("f1_pc4",   if_pc_plus4, 32'h0040_0004);
    check_eq("b2b_req",  32'(imem_req), 32'd1);
    check_eq("b2b_addr", imem_addr, 32'h0040_0004);
    check_eq("b2b_pcw",  32'(pc_write), 32'd1);

    // Flush with same-cycle ack: data discarded, PC not advanced
    imem_rdata = 32'hDEAD_BEEF;
    flush      = 1'b1;
    #1;
    check_eq("fl_pcw", 32'(pc_write), 32'd0);
    step();
    flush = 1'b0;
    check_eq("fl_valid", 32'(if_valid), 32'd0);
    check_eq("fl_instr", if_instr, 32'h0000_0000);
    check_eq("fl_pcin",  pc_in, P0);

    // Stream of three with a two-cycle stall after the first capture
    n_pcw      = 0;
    imem_rdata = 32'h1111_1111;
    step();
    stall      = 1'b1;
    imem_rdata = 32'h2222_2222;
    #1;
    check_eq("st_b_req",   32'(imem_req), 32'd0);
    check_eq("st_b_instr", if_instr, 32'h1111_1111);
    step();
    check_eq("st_c_req",   32'(imem_req), 32'd0);
    check_eq("st_c_instr", if_instr, 32'h1111_1111);
    check_eq("st_c_valid", 32'(if_valid), 32'd1);
    step();
    stall = 1'b0;
    #1;
    check_eq("st_d_req", 32'(imem_req), 32'd0);
    step();
    check_eq("st_e_req",  32'(imem_req), 32'd1);
    check_eq("st_e_addr", imem_addr, P0 + 32'd4);
    step();
    check_eq("st_e_instr", if_instr, 32'h2222_2222);
    check_eq("st_e_pc",    if_pc, P0 + 32'd4);
    imem_rdata = 32'h3333_3333;
    step();
    check_eq("st_f_instr", if_instr, 32'h3333_3333);
    check_eq("st_f_pc",    if_pc, P0 + 32'd8);
    check_eq("st_pcw_cnt", n_pcw, 32'd3);

    // Fetch timeout after 16 un-acked request cycles
    imem_ack = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      check_eq("to_req", 32'(imem_req), 32'd1);
      check_eq("to_pcw", 32'(pc_write), 32'd0);
      if (i == 15) check_eq("to_err_early", 32'(err_code), 32'd0);
      step();
    end
    check_eq("to_err",   32'(err_code), 32'd2);
    check_eq("to_req0",  32'(imem_req), 32'd0);
    check_eq("to_valid", 32'(if_valid), 32'd0);
    imem_ack = 1'b1;
    #1;
    check_eq("err_req", 32'(imem_req), 32'd0);
    check_eq("err_pcw", 32'(pc_write), 32'd0);
    step();
    check_eq("err_sticky", 32'(err_code), 32'd2);

    // Misaligned PC: no request, error 01, recovered by flush
    flush = 1'b1;
    pc_in = 32'h0040_0002;
    step();
    flush = 1'b0;
    #1;
    check_eq("mis_err0", 32'(err_code), 32'd0);
    check_eq("mis_req",  32'(imem_req), 32'd0);
    step();
    check_eq("mis_err",   32'(err_code), 32'd1);
    check_eq("mis_valid", 32'(if_valid), 32'd0);
    check_eq("mis_req2",  32'(imem_req), 32'd0);
    step();
    check_eq("mis_sticky", 32'(err_code), 32'd1);
    flush = 1'b1;
    pc_in = 32'h0040_0100;
    #1;
    check_eq("mis_fl_pcw", 32'(pc_write), 32'd0);
    step();
    flush = 1'b0;
    #1;
    check_eq("res_err",  32'(err_code), 32'd0);
    check_eq("res_req",  32'(imem_req), 32'd1);
    check_eq("res_addr", imem_addr, 32'h0040_0100);
    check_eq("res_pcw",  32'(pc_write), 32'd1);
    imem_rdata = 32'h4444_4444;
    step();
    check_eq("res_instr", if_instr, 32'h4444_4444);
    check_eq("res_pc",    if_pc, 32'h0040_0100);

    // if_pc_plus4 wraps at the top of the address space
    pc_in      = 32'hFFFF_FFFC;
    imem_rdata = 32'h5555_5555;
    step();
    check_eq("wrap_pc",  if_pc, 32'hFFFF_FFFC);
    check_eq("wrap_pc4", if_pc_plus4, 32'h0000_0000);

    // Flush while stalled in HOLD still flushes
    stall    = 1'b1;
    imem_ack = 1'b0;
    #1;
    check_eq("hs_req", 32'(imem_req), 32'd0);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_eq("hs_valid", 32'(if_valid), 32'd0);
    check_eq("hs_instr", if_instr, 32'h0000_0000);
    stall = 1'b0;
    #1;
    check_eq("hs_req2", 32'(imem_req), 32'd1);

    // Asynchronous reset while a request is outstanding
    Reset = 1'b1;
    #1;
    check_eq("ar_req",   32'(imem_req), 32'd0);
    check_eq("ar_pcw",   32'(pc_write), 32'd0);
    check_eq("ar_valid", 32'(if_valid), 32'd0);
    check_eq("ar_instr", if_instr, 32'h0000_0000);
    check_eq("ar_pc",    if_pc, 32'h0000_0000);
    check_eq("ar_err",   32'(err_code), 32'd0);
    imem_ack = 1'b1;
    step();
    step();
    check_eq("ar_late_valid", 32'(if_valid), 32'd0);
    check_eq("ar_late_req",   32'(imem_req), 32'd0);
    Reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
